// File: rtl/bayer_demosaic.sv
// rtl/bayer_demosaic.sv - Bayer-to-RGB demosaic over a 2x2 window with line buffer
`timescale 1ns/1ps
module bayer_demosaic #(
    parameter int DW     = 10,
    parameter int CW     = 11,
    parameter int LINE_W = 1280,
    parameter int AW     = 11
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic [DW-1:0] iDATA,
    input  logic          iDVAL,
    input  logic [CW-1:0] iX_Cont,
    input  logic [CW-1:0] iY_Cont,
    input  logic [1:0]    iPHASE,
    input  logic          iMODE,
    output logic [DW-1:0] oRed,
    output logic [DW-1:0] oGreen,
    output logic [DW-1:0] oBlue,
    output logic          oDVAL,
    output logic [CW-1:0] oX_Cont,
    output logic [CW-1:0] oY_Cont
);

    localparam logic [CW-1:0] X_LIM = CW'(LINE_W);

    logic [DW-1:0] mem [LINE_W];
    logic          acc, wv;
    logic [AW-1:0] addr;

    // stage 0: window samples and per-pixel controls
    logic          armed_q, armed_d;
    logic [DW-1:0] cur_q, cur_d, prv_q, prv_d, bl_q, bl_d, tl_q, tl_d;
    logic [CW-1:0] x_q, x_d, y_q, y_d;
    logic [1:0]    phase_q, phase_d;
    logic          mode_q, mode_d, wv_q, wv_d;
    // stage 1: selected channels
    logic [DW-1:0] red1_q, red1_d, grn1_q, grn1_d, blu1_q, blu1_d;
    logic [CW-1:0] ox1_q, ox1_d, oy1_q, oy1_d;
    logic          vld1_q, vld1_d;
    // stage 2: output registers
    logic [DW-1:0] red_q, red_d, grn_q, grn_d, blu_q, blu_d;
    logic [CW-1:0] ox_q, ox_d, oy_q, oy_d;
    logic          vld_q, vld_d;

    logic [DW-1:0] win [4];
    logic [1:0]    code_br;
    logic [DW:0]   gsum;

    assign acc  = iDVAL && (iX_Cont < X_LIM);
    assign wv   = acc && (iX_Cont != '0) && (iY_Cont != '0) && armed_q;
    assign addr = iX_Cont[AW-1:0];

    // read-before-write: the registered read below sees last row's sample
    always_ff @(posedge iCLK) begin
        if (acc) mem[addr] <= iDATA;
    end

    always_comb begin
        armed_d = armed_q | (acc && (iY_Cont == '0));
        cur_d   = cur_q;
        prv_d   = prv_q;
        bl_d    = bl_q;
        tl_d    = tl_q;
        x_d     = x_q;
        y_d     = y_q;
        phase_d = phase_q;
        mode_d  = mode_q;
        wv_d    = wv;
        if (acc) begin
            bl_d    = cur_q;
            tl_d    = prv_q;
            cur_d   = iDATA;
            prv_d   = mem[addr];
            x_d     = iX_Cont;
            y_d     = iY_Cont;
            phase_d = iPHASE;
            mode_d  = iMODE;
        end
    end

    // window index = position offset from BR; a sample coded c sits at code_br ^ c
    always_comb begin
        code_br = {y_q[0] ^ phase_q[1], x_q[0] ^ phase_q[0]};
        win[0]  = cur_q;
        win[1]  = bl_q;
        win[2]  = prv_q;
        win[3]  = tl_q;
        gsum    = {1'b0, win[code_br]} + {1'b0, win[code_br ^ 2'b11]};
        vld1_d  = wv_q && (mode_q || (x_q[0] && y_q[0]));
        red1_d  = red1_q;
        grn1_d  = grn1_q;
        blu1_d  = blu1_q;
        ox1_d   = ox1_q;
        oy1_d   = oy1_q;
        if (vld1_d) begin
            red1_d = win[code_br ^ 2'b01];
            blu1_d = win[code_br ^ 2'b10];
            grn1_d = gsum[DW:1];
            ox1_d  = mode_q ? x_q - CW'(1) : {1'b0, x_q[CW-1:1]};
            oy1_d  = mode_q ? y_q - CW'(1) : {1'b0, y_q[CW-1:1]};
        end
    end

    always_comb begin
        vld_d = vld1_q;
        red_d = vld1_q ? red1_q : red_q;
        grn_d = vld1_q ? grn1_q : grn_q;
        blu_d = vld1_q ? blu1_q : blu_q;
        ox_d  = vld1_q ? ox1_q  : ox_q;
        oy_d  = vld1_q ? oy1_q  : oy_q;
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            armed_q <= 1'b0;
            cur_q   <= '0;
            prv_q   <= '0;
            bl_q    <= '0;
            tl_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            phase_q <= '0;
            mode_q  <= 1'b0;
            wv_q    <= 1'b0;
            red1_q  <= '0;
            grn1_q  <= '0;
            blu1_q  <= '0;
            ox1_q   <= '0;
            oy1_q   <= '0;
            vld1_q  <= 1'b0;
            red_q   <= '0;
            grn_q   <= '0;
            blu_q   <= '0;
            ox_q    <= '0;
            oy_q    <= '0;
            vld_q   <= 1'b0;
        end else begin
            armed_q <= armed_d;
            cur_q   <= cur_d;
            prv_q   <= prv_d;
            bl_q    <= bl_d;
            tl_q    <= tl_d;
            x_q     <= x_d;
            y_q     <= y_d;
            phase_q <= phase_d;
            mode_q  <= mode_d;
            wv_q    <= wv_d;
            red1_q  <= red1_d;
            grn1_q  <= grn1_d;
            blu1_q  <= blu1_d;
            ox1_q   <= ox1_d;
            oy1_q   <= oy1_d;
            vld1_q  <= vld1_d;
            red_q   <= red_d;
            grn_q   <= grn_d;
            blu_q   <= blu_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
            vld_q   <= vld_d;
        end
    end

    assign oRed    = red_q;
    assign oGreen  = grn_q;
    assign oBlue   = blu_q;
    assign oX_Cont = ox_q;
    assign oY_Cont = oy_q;
    assign oDVAL   = vld_q;

endmodule

// File: tb/tb_bayer_demosaic.sv
// tb/tb_bayer_demosaic.sv - self-checking bench for bayer_demosaic
`timescale 1ns/1ps
module tb_bayer_demosaic;
    localparam int DW = 10;
    localparam int CW = 11;
    localparam int LW = 8;
    localparam int AW = 3;

    logic          iCLK = 1'b0;
    logic          iRST = 1'b0;
    logic [DW-1:0] iDATA = '0;
    logic          iDVAL = 1'b0;
    logic [CW-1:0] iX_Cont = '0;
    logic [CW-1:0] iY_Cont = '0;
    logic [1:0]    iPHASE = '0;
    logic          iMODE = 1'b0;
    logic [DW-1:0] oRed, oGreen, oBlue;
    logic          oDVAL;
    logic [CW-1:0] oX_Cont, oY_Cont;

    bayer_demosaic #(.DW(DW), .CW(CW), .LINE_W(LW), .AW(AW)) dut (
        .iCLK(iCLK), .iRST(iRST), .iDATA(iDATA), .iDVAL(iDVAL),
        .iX_Cont(iX_Cont), .iY_Cont(iY_Cont), .iPHASE(iPHASE), .iMODE(iMODE),
        .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue), .oDVAL(oDVAL),
        .oX_Cont(oX_Cont), .oY_Cont(oY_Cont)
    );

    always #5 iCLK = ~iCLK;

    int cyc = 0;
    always @(posedge iCLK) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [63:0] pack(input int r, input int g, input int b, input int ox, input int oy);
        return {12'd0, r[9:0], g[9:0], b[9:0], ox[10:0], oy[10:0]};
    endfunction

    typedef struct { logic [63:0] v; int due; } exp_t;
    typedef struct { logic [63:0] v; int at; } cap_t;
    exp_t expq[$];
    cap_t capq[$];

    int img [16][16];
    int rnd_img [16][16];
    bit m_armed = 1'b0;
    int last_trig = 0;

    // Reference: look at the four window pixels in the frame and sort them by colour code
    task automatic push_model(input int y, input int x, input int ph, input int md);
        int r, b, g1, g2, yy, xx, code;
        if (!m_armed || x < 1 || y < 1 || x >= LW) return;
        if (md == 0 && !((x % 2 == 1) && (y % 2 == 1))) return;
        r = 0; b = 0; g1 = 0; g2 = 0;
        for (int dy = 0; dy < 2; dy++) begin
            for (int dx = 0; dx < 2; dx++) begin
                yy = y - dy;
                xx = x - dx;
                code = 2 * ((yy % 2) ^ ((ph >> 1) & 1)) + ((xx % 2) ^ (ph & 1));
                case (code)
                    0: g1 = img[yy][xx];
                    1: r  = img[yy][xx];
                    2: b  = img[yy][xx];
                    default: g2 = img[yy][xx];
                endcase
            end
        end
        expq.push_back('{pack(r, (g1 + g2) / 2, b, md ? x - 1 : x / 2, md ? y - 1 : y / 2), cyc + 3});
    endtask

    task automatic drive(input int y, input int x, input int d, input int ph, input int md, input bit dv);
        @(negedge iCLK);
        iDATA   = DW'(d);
        iX_Cont = CW'(x);
        iY_Cont = CW'(y);
        iPHASE  = 2'(ph);
        iMODE   = md[0];
        iDVAL   = dv;
        if (dv && x < LW) begin
            img[y][x] = d;
            if (y == 0) m_armed = 1'b1;
            push_model(y, x, ph, md);
        end
        last_trig = cyc + 1;
    endtask

    task automatic idle();
        drive(int'($urandom_range(15)), int'($urandom_range(15)), int'($urandom_range(1023)),
              int'($urandom_range(3)), int'($urandom_range(1)), 1'b0);
    endtask

    task automatic fill_rnd();
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++)
                rnd_img[y][x] = int'($urandom_range(1023));
    endtask

    task automatic run_frame(input int w, input int h, input int pat, input int ph, input int md,
                             input bit rnd_ctl, input int gap_pct, input int ty, input int tx,
                             output int trig);
        int d, p, m, xe;
        trig = -1;
        xe = (w == LW) ? w + 2 : w;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < xe; x++) begin
                while (int'($urandom_range(99)) < gap_pct) idle();
                d = (pat == 0) ? 16 * y + x : (pat == 1) ? 1023 : rnd_img[y][x];
                p = rnd_ctl ? int'($urandom_range(3)) : ph;
                m = rnd_ctl ? int'($urandom_range(1)) : md;
                drive(y, x, d, p, m, 1'b1);
                if (y == ty && x == tx) trig = last_trig;
            end
        end
        repeat (4) idle();
    endtask

    always @(negedge iCLK) begin
        if (iRST) begin
            while (expq.size() > 0 && expq[0].due < cyc) begin
                check("output_missing_at_cycle", 64'(cyc), 64'(expq[0].due));
                void'(expq.pop_front());
            end
            if (oDVAL) begin
                capq.push_back('{pack(int'(oRed), int'(oGreen), int'(oBlue), int'(oX_Cont), int'(oY_Cont)), cyc});
                if (expq.size() == 0) check("unexpected_oDVAL", 64'(1), 64'(0));
                else begin
                    check("out_value", pack(int'(oRed), int'(oGreen), int'(oBlue), int'(oX_Cont), int'(oY_Cont)), expq[0].v);
                    check("out_latency", 64'(cyc), 64'(expq[0].due));
                    void'(expq.pop_front());
                end
            end
        end
    end

    typedef struct { int pat, ph, md, ty, tx, r, g, b, ox, oy, pulses; } vec_t;
    vec_t vecs [4];

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int trig, found;
        cap_t ref_run[$];

        vecs[0] = '{0, 0, 0, 1, 1, 1, 8, 16, 0, 0, 4};
        vecs[1] = '{0, 0, 1, 1, 2, 1, 9, 18, 1, 0, 9};
        vecs[2] = '{0, 3, 0, 1, 1, 16, 8, 1, 0, 0, 4};
        vecs[3] = '{1, 0, 1, 1, 1, 1023, 1023, 1023, 0, 0, 9};

        repeat (3) @(negedge iCLK);
        check("reset_oDVAL", 64'(oDVAL), 64'(0));
        check("reset_oRed", 64'(oRed), 64'(0));
        check("reset_oGreen", 64'(oGreen), 64'(0));
        check("reset_oBlue", 64'(oBlue), 64'(0));
        check("reset_oX", 64'(oX_Cont), 64'(0));
        check("reset_oY", 64'(oY_Cont), 64'(0));
        iRST = 1'b1;

        for (int i = 0; i < 4; i++) begin
            capq.delete();
            run_frame(4, 4, vecs[i].pat, vecs[i].ph, vecs[i].md, 1'b0, 0, vecs[i].ty, vecs[i].tx, trig);
            check($sformatf("vec%0d_pulses", i), 64'(capq.size()), 64'(vecs[i].pulses));
            found = 0;
            foreach (capq[k]) begin
                if (capq[k].at == trig + 2) begin
                    found = 1;
                    check($sformatf("vec%0d_rgbxy", i), capq[k].v,
                          pack(vecs[i].r, vecs[i].g, vecs[i].b, vecs[i].ox, vecs[i].oy));
                end
            end
            check($sformatf("vec%0d_output_found", i), 64'(found), 64'(1));
        end

        for (int ph = 0; ph < 4; ph++) begin
            for (int md = 0; md < 2; md++) begin
                fill_rnd();
                run_frame(LW, 6, 2, ph, md, 1'b0, 0, -1, -1, trig);
            end
        end
        repeat (2) begin
            fill_rnd();
            run_frame(LW, 6, 2, 0, 0, 1'b1, 30, -1, -1, trig);
        end

        fill_rnd();
        capq.delete();
        run_frame(LW, 6, 2, 1, 1, 1'b0, 0, -1, -1, trig);
        ref_run = capq;
        capq.delete();
        run_frame(LW, 6, 2, 1, 1, 1'b0, 50, -1, -1, trig);
        check("gap_run_count", 64'(capq.size()), 64'(ref_run.size()));
        for (int k = 0; k < ref_run.size() && k < capq.size(); k++)
            check($sformatf("gap_run_item%0d", k), capq[k].v, ref_run[k].v);

        fill_rnd();
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < ((y == 2) ? 5 : LW); x++)
                drive(y, x, rnd_img[y][x], 2, 1, 1'b1);
        @(negedge iCLK);
        iDVAL = 1'b0;
        #1 iRST = 1'b0;
        #1 check("async_reset_clears_oDVAL", 64'(oDVAL), 64'(0));
        expq.delete();
        m_armed = 1'b0;
        repeat (2) @(negedge iCLK);
        iRST = 1'b1;
        capq.delete();
        for (int x = 0; x < LW; x++) drive(3, x, rnd_img[3][x], 2, 1, 1'b1);
        repeat (4) idle();
        check("no_output_before_row0", 64'(capq.size()), 64'(0));
        fill_rnd();
        capq.delete();
        run_frame(LW, 4, 2, 2, 1, 1'b0, 0, -1, -1, trig);
        check("post_reset_frame_pulses", 64'(capq.size()), 64'(3 * (LW - 1)));

        repeat (4) idle();
        check("scoreboard_drained", 64'(expq.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/bayer_demosaic.md
# bayer_demosaic

Parametrised Bayer-to-RGB converter sitting between the CCD capture stage and the frame-buffer/downscaler path of the camera pipeline. It builds a 2x2 neighbourhood from the raw pixel stream using an internal line buffer, then produces one RGB triple per window. It supports a selectable Bayer phase and two output modes: 2x2 decimation (one pixel per quad) and full resolution (one pixel per input pixel).

## Interface
- DW, 10, raw and per-channel colour width.
- CW, 11, width of the X/Y coordinate counters.
- LINE_W, 1280, maximum pixels per line, which is the line-buffer depth.
- AW, 11, line-buffer address width; must satisfy 2^AW >= LINE_W.
- iCLK  in  1  pixel clock.
- iRST  in  1  asynchronous, active-low reset.
- iDATA  in  DW  raw Bayer sample.
- iDVAL  in  1  sample valid; also the clock enable for the window pipeline.
- iX_Cont  in  CW  column of iDATA, starting at 0.
- iY_Cont  in  CW  row of iDATA, starting at 0.
- iPHASE  in  2  Bayer phase, as {row flip, column flip}.
- iMODE  in  1  output mode: 0 = decimate 2x2, 1 = full resolution.
- oRed, oGreen, oBlue  out  DW each  colour outputs, registered.
- oDVAL  out  1  output valid, registered.
- oX_Cont, oY_Cont  out  CW each  output-pixel coordinates, registered.

## Operation
- Colour code of pixel (y,x): c = {y[0]^iPHASE[1], x[0]^iPHASE[0]}.
  - 00 = G1, 01 = R, 10 = B, 11 = G2.
  - Phase 0 is therefore GRBG.
- Line buffer: single-port-style RAM of LINE_W x DW.
  - On iDVAL with iX_Cont < LINE_W, address iX_Cont is read and written in the same cycle.
  - Read-before-write: the read returns the previous row's sample.
  - RAM contents are never reset.
- Window for the current pixel at (y,x):
  - BR = cur(x), BL = cur(x-1), TR = prev(x), TL = prev(x-1).
  - BL and TL are held in registers that advance only on accepted pixels.
- Channel selection:
  - R = the window sample coded 01.
  - B = the window sample coded 10.
  - G = (G1 + G2) >> 1, with the sum computed in DW+1 bits and truncated, with no overflow.
  - Selection uses the stage-1 registered copies of iPHASE, y[0] and x[0].
- Window valid (wv) requires all of: iDVAL, x >= 1, y >= 1, x < LINE_W, and armed = 1.
- Mode 0 (decimate):
  - Output only when wv and x[0] = 1 and y[0] = 1.
  - oX = x >> 1, oY = y >> 1.
- Mode 1 (full resolution):
  - Output on every wv.
  - oX = x - 1, oY = y - 1, which is the window's top-left pixel.
- iMODE and iPHASE are sampled into stage 1 with each pixel. Changing them mid-frame is legal; the result is per-pixel mixed output, with no corruption of pipeline state.
- armed flag:
  - Cleared by reset.
  - Set by the first accepted pixel with iY_Cont = 0.
  - This guarantees the prev row was written since reset, so stale RAM content is never output.
- Pixels with x >= LINE_W are neither written nor output. They do not advance BL/TL.
- When iDVAL is low, no RAM write occurs, BL/TL hold, and oDVAL = 0 in the corresponding output cycle. Gaps are transparent to the result.

## Timing
- Reset values: oRed, oGreen, oBlue, oX_Cont and oY_Cont = 0; oDVAL = 0; all pipeline registers = 0; armed = 0.
- Stage 0 (cycle N): iDATA is written and the RAM read is issued. iDATA, x, y, iPHASE, iMODE and the wv term are registered.
- Stage 1 (cycle N+1): prev(x) is available at the RAM output. The channels are computed.
- Stage 2 (cycle N+2): the output registers are loaded.
- Latency: an input accepted at edge N appears at the outputs after edge N+2.
- oDVAL is a single-cycle qualifier. The outputs hold their last values while oDVAL = 0.
- Throughput:
  - Mode 1: one output per accepted input with x, y >= 1.
  - Mode 0: one output per 4 inputs.
- BL/TL at x = 0 contain the previous line's last pixel. This is harmless because x = 0 is never valid.
- An asynchronous reset mid-frame:
  - Clears oDVAL immediately.
  - Suppresses output until the next row-0 pixel.
  - Does not reset the RAM.

## Test plan
- Reset then a 4x4 frame with iDATA = 16y + x, iPHASE = 0, iMODE = 0:
  - At quad (1,1): oRed = 1, oGreen = 8, oBlue = 16, oX = 0, oY = 0.
  - Exactly 4 oDVAL pulses for the frame, each 2 cycles after the triggering input.
- Same frame with iMODE = 1:
  - At input (1,2): oRed = 1, oGreen = 9, oBlue = 18, oX = 1, oY = 0.
  - Exactly 9 oDVAL pulses; no output for row 0 or column 0.
- Same frame with iPHASE = 3, iMODE = 0:
  - At (1,1): oRed = 16, oGreen = 8, oBlue = 1.
  - Sweep all 4 phases against a reference model.
- All samples = 1023, full-resolution mode: oGreen = 1023 (no wrap); oRed = oBlue = 1023.
- Frame fed with random iDVAL gaps (about 50% duty): the output sequence is identical to the gap-free run.
- Assert iRST low mid-row 2, release, then resume at row 3: no oDVAL until row 0 of the next frame; the next frame is then correct.
